// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory access controller.
// Size codes, FSM state encoding, requester ids and the registered request record.
package dmem_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_arb_sel.sv
// Grant selection between the two requesters of the data-memory port.
// Default: M0 priority with an M1 starvation override; DMEM_ARB_RR_EN selects round-robin.
module dmem_arb_sel
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       idle_i,
  output logic [1:0] gnt_o
);

`ifdef DMEM_ARB_RR_EN
  // Pointer remembers who was served last; reset value lets M0 win the first contention.
  logic last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (idle_i) begin
      if (req0_i && req1_i) gnt_o = (last_q == REQ_M0) ? 2'b10 : 2'b01;
      else if (req0_i)      gnt_o = 2'b01;
      else if (req1_i)      gnt_o = 2'b10;
      if (gnt_o[1])      last_d = REQ_M1;
      else if (gnt_o[0]) last_d = REQ_M0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= REQ_M1;
    else     last_q <= last_d;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  always_comb begin
    gnt_o    = 2'b00;
    starve_d = starve_q;
    if (idle_i) begin
      if (req1_i && (starve_q == LIMIT)) gnt_o = 2'b10;
      else if (req0_i)                   gnt_o = 2'b01;
      else if (req1_i)                   gnt_o = 2'b10;
      if (gnt_o[1])                                       starve_d = 4'd0;
      else if (gnt_o[0] && req1_i && (starve_q != LIMIT)) starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= 4'd0;
    else     starve_q <= starve_d;
  end
`endif

endmodule

// File: rtl/dmem_access_ctrl.sv
// MA-stage sequencer/arbiter sharing one DATA_MEMORY port between two requesters.
// Optional macro DMEM_ARB_RR_EN switches arbitration to round-robin.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [1:0]  M0_SIZE,
  input  logic        M0_UNSIGNED,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  output logic        M0_GNT,
  output logic        M0_RVALID,
  output logic [31:0] M0_RDATA,
  output logic        M0_ERR,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [1:0]  M1_SIZE,
  input  logic        M1_UNSIGNED,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  output logic        M1_GNT,
  output logic        M1_RVALID,
  output logic [31:0] M1_RDATA,
  output logic        M1_ERR,
  output logic [1:0]  MEM_WRITE,
  output logic [1:0]  MEM_READ,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_DATA_IN,
  input  logic [31:0] MEM_DATA_OUT,
  output logic        BUSY
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_e      state_q, state_d;
  req_t        req_q, req_d, win;
  logic        owner_q, owner_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  lat_q, lat_d;
  logic [1:0]  gnt;
  logic        win_err;
  logic        arb_idle;
  logic [31:0] ext_data;

  // Grants are only offered from IDLE and never while reset is asserted.
  assign arb_idle = (state_q == ST_IDLE) && !RESET;

  dmem_arb_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk   (CLK),
    .rst   (RESET),
    .req0_i(M0_REQ),
    .req1_i(M1_REQ),
    .idle_i(arb_idle),
    .gnt_o (gnt)
  );

  always_comb begin
    if (gnt[1]) win = '{we: M1_WE, size: M1_SIZE, uns: M1_UNSIGNED, addr: M1_ADDR, wdata: M1_WDATA};
    else        win = '{we: M0_WE, size: M0_SIZE, uns: M0_UNSIGNED, addr: M0_ADDR, wdata: M0_WDATA};
  end

  always_comb begin
    win_err = 1'b0;
    case (win.size)
      SZ_NONE: win_err = 1'b1;
      SZ_HALF: win_err = win.addr[0];
      SZ_WORD: win_err = |win.addr[1:0];
      default: win_err = 1'b0;
    endcase
  end

  always_comb begin
    ext_data = MEM_DATA_OUT;
    case (req_q.size)
      SZ_BYTE: ext_data = req_q.uns ? {24'h0, MEM_DATA_OUT[7:0]}
                                    : {{24{MEM_DATA_OUT[7]}}, MEM_DATA_OUT[7:0]};
      SZ_HALF: ext_data = req_q.uns ? {16'h0, MEM_DATA_OUT[15:0]}
                                    : {{16{MEM_DATA_OUT[15]}}, MEM_DATA_OUT[15:0]};
      default: ext_data = MEM_DATA_OUT;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    owner_d = owner_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          req_d   = win;
          owner_d = gnt[1] ? REQ_M1 : REQ_M0;
          err_d   = win_err;
          rdata_d = 32'h0;
          lat_d   = 3'd0;
          state_d = win_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (lat_q == LAT_LAST) begin
          if (!req_q.we) rdata_d = ext_data;
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      owner_q <= REQ_M0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      lat_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
    end
  end

  // Memory command is driven purely from state so an async reset drops it at once.
  always_comb begin
    MEM_ADDR    = 32'h0;
    MEM_DATA_IN = 32'h0;
    MEM_WRITE   = SZ_NONE;
    MEM_READ    = SZ_NONE;
    if (state_q == ST_ACCESS) begin
      MEM_ADDR    = req_q.addr;
      MEM_DATA_IN = req_q.wdata;
      if (req_q.we) MEM_WRITE = req_q.size;
      else          MEM_READ  = req_q.size;
    end
  end

  assign M0_GNT    = gnt[0];
  assign M1_GNT    = gnt[1];
  assign M0_RVALID = (state_q == ST_RESP) && (owner_q == REQ_M0);
  assign M1_RVALID = (state_q == ST_RESP) && (owner_q == REQ_M1);
  assign M0_RDATA  = M0_RVALID ? rdata_q : 32'h0;
  assign M1_RDATA  = M1_RVALID ? rdata_q : 32'h0;
  assign M0_ERR    = M0_RVALID && err_q;
  assign M1_ERR    = M1_RVALID && err_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: instance A (MEM_LAT=1) with a byte memory model,
// instance B (MEM_LAT=4) with a fixed read pattern for latency and reset-abort checks.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          errors = 0;
  int          checks = 0;

  logic        m0_req = 0, m0_we = 0, m0_uns = 0;
  logic [1:0]  m0_size = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0;
  logic        m1_req = 0, m1_we = 0, m1_uns = 0;
  logic [1:0]  m1_size = 0;
  logic [31:0] m1_addr = 0, m1_wdata = 0;
  logic        b_m0_req = 0, b_m1_req = 0;

  logic        a_m0_gnt, a_m0_rvalid, a_m0_err, a_m1_gnt, a_m1_rvalid, a_m1_err, a_busy;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_din, a_mem_dout;
  logic [1:0]  a_mem_write, a_mem_read;
  logic        b_m0_gnt, b_m0_rvalid, b_m0_err, b_m1_gnt, b_m1_rvalid, b_m1_err, b_busy;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_din, b_mem_dout;
  logic [1:0]  b_mem_write, b_mem_read;

  logic [7:0]  mem [0:255];
  logic [7:0]  wa, wa1, wa2, wa3;

  dmem_access_ctrl #(.MEM_LAT(1), .STARVE_LIMIT(4)) u_dut_a (
    .CLK(clk), .RESET(rst),
    .M0_REQ(m0_req), .M0_WE(m0_we), .M0_SIZE(m0_size), .M0_UNSIGNED(m0_uns),
    .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata), .M0_GNT(a_m0_gnt), .M0_RVALID(a_m0_rvalid),
    .M0_RDATA(a_m0_rdata), .M0_ERR(a_m0_err),
    .M1_REQ(m1_req), .M1_WE(m1_we), .M1_SIZE(m1_size), .M1_UNSIGNED(m1_uns),
    .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata), .M1_GNT(a_m1_gnt), .M1_RVALID(a_m1_rvalid),
    .M1_RDATA(a_m1_rdata), .M1_ERR(a_m1_err),
    .MEM_WRITE(a_mem_write), .MEM_READ(a_mem_read), .MEM_ADDR(a_mem_addr),
    .MEM_DATA_IN(a_mem_din), .MEM_DATA_OUT(a_mem_dout), .BUSY(a_busy)
  );

  dmem_access_ctrl #(.MEM_LAT(4), .STARVE_LIMIT(4)) u_dut_b (
    .CLK(clk), .RESET(rst),
    .M0_REQ(b_m0_req), .M0_WE(m0_we), .M0_SIZE(m0_size), .M0_UNSIGNED(m0_uns),
    .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata), .M0_GNT(b_m0_gnt), .M0_RVALID(b_m0_rvalid),
    .M0_RDATA(b_m0_rdata), .M0_ERR(b_m0_err),
    .M1_REQ(b_m1_req), .M1_WE(m1_we), .M1_SIZE(m1_size), .M1_UNSIGNED(m1_uns),
    .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata), .M1_GNT(b_m1_gnt), .M1_RVALID(b_m1_rvalid),
    .M1_RDATA(b_m1_rdata), .M1_ERR(b_m1_err),
    .MEM_WRITE(b_mem_write), .MEM_READ(b_mem_read), .MEM_ADDR(b_mem_addr),
    .MEM_DATA_IN(b_mem_din), .MEM_DATA_OUT(b_mem_dout), .BUSY(b_busy)
  );

  always #5 clk = ~clk;

  // Byte-addressed little-endian memory behind instance A; sub-word reads carry junk upper bits.
  assign wa  = a_mem_addr[7:0];
  assign wa1 = wa + 8'd1;
  assign wa2 = wa + 8'd2;
  assign wa3 = wa + 8'd3;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      case (a_mem_write)
        2'b01: mem[wa] <= a_mem_din[7:0];
        2'b10: begin mem[wa] <= a_mem_din[7:0]; mem[wa1] <= a_mem_din[15:8]; end
        2'b11: begin
          mem[wa]  <= a_mem_din[7:0];   mem[wa1] <= a_mem_din[15:8];
          mem[wa2] <= a_mem_din[23:16]; mem[wa3] <= a_mem_din[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    a_mem_dout = 32'h0;
    case (a_mem_read)
      2'b01:   a_mem_dout = {24'hA5A5A5, mem[wa]};
      2'b10:   a_mem_dout = {16'hA5A5, mem[wa1], mem[wa]};
      2'b11:   a_mem_dout = {mem[wa3], mem[wa2], mem[wa1], mem[wa]};
      default: a_mem_dout = 32'h0;
    endcase
  end

  assign b_mem_dout = (b_mem_read != 2'b00) ? 32'hCAFE_F00D : 32'h0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on instance A; returns data, error flag, GNT-to-RVALID cycles, and whether a memory command appeared.
  task automatic acc_a(input logic port, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat, output logic cmd);
    int n;
    cmd = 1'b0;
    if (port) begin m1_req = 1; m1_we = we; m1_size = size; m1_uns = uns; m1_addr = addr; m1_wdata = wdata; end
    else      begin m0_req = 1; m0_we = we; m0_size = size; m0_uns = uns; m0_addr = addr; m0_wdata = wdata; end
    #1;
    n = 0;
    while (!(port ? a_m1_gnt : a_m0_gnt) && n < 20) begin step(); #1; n++; end
    chk("gnt_seen", {31'h0, (port ? a_m1_gnt : a_m0_gnt)}, 32'h1);
    step();
    m0_req = 0; m1_req = 0;
    lat = 1;
    #1;
    while (!(port ? a_m1_rvalid : a_m0_rvalid) && lat < 20) begin
      cmd |= (a_mem_read != 2'b00) || (a_mem_write != 2'b00);
      step(); #1; lat++;
    end
    chk("rvalid_seen", {31'h0, (port ? a_m1_rvalid : a_m0_rvalid)}, 32'h1);
    rdata = port ? a_m1_rdata : a_m0_rdata;
    err   = port ? a_m1_err : a_m0_err;
    step();
  endtask

  task automatic run_a(input string tag, input logic port, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er, cmd;
    int          lat;
    acc_a(port, we, size, uns, addr, wdata, rd, er, lat, cmd);
    chk({tag, "_rdata"}, rd, exp_rdata);
    chk({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
    chk({tag, "_lat"}, lat, exp_err ? 32'd1 : 32'd2);
    chk({tag, "_cmd"}, {31'h0, cmd}, {31'h0, !exp_err});
  endtask

  initial begin
    int          k, n;
    logic [31:0] exp_g;
    logic        seen;

    // Reset: outputs quiet even with a request pending.
    repeat (3) @(posedge clk);
    #2;
    m0_req = 1; m0_size = 2'b11; #1;
    chk("rst_gnt", {31'h0, a_m0_gnt}, 32'h0);
    chk("rst_busy", {31'h0, a_busy}, 32'h0);
    chk("rst_mem_read", {30'h0, a_mem_read}, 32'h0);
    chk("rst_mem_write", {30'h0, a_mem_write}, 32'h0);
    chk("rst_rvalid", {31'h0, a_m0_rvalid}, 32'h0);
    m0_req = 0;
    step();
    rst = 0;
    step();

    // Word store/load round trip and sub-word extension.
    run_a("st_word",   0, 1, 2'b11, 0, 32'h00, 32'hDEADBEEF, 32'h0,        0);
    run_a("ld_word",   0, 0, 2'b11, 0, 32'h00, 32'h0,        32'hDEADBEEF, 0);
    run_a("st_b21",    0, 1, 2'b01, 0, 32'h21, 32'h12345680, 32'h0,        0);
    run_a("st_b20",    0, 1, 2'b01, 0, 32'h20, 32'h00000001, 32'h0,        0);
    run_a("ld_sb21",   0, 0, 2'b01, 0, 32'h21, 32'h0,        32'hFFFFFF80, 0);
    run_a("ld_ub21",   0, 0, 2'b01, 1, 32'h21, 32'h0,        32'h00000080, 0);
    run_a("ld_sh20",   0, 0, 2'b10, 0, 32'h20, 32'h0,        32'hFFFF8001, 0);
    run_a("ld_uh20",   0, 0, 2'b10, 1, 32'h20, 32'h0,        32'h00008001, 0);
    run_a("ld_w20",    0, 0, 2'b11, 0, 32'h20, 32'h0,        32'h00008001, 0);
    run_a("ld_sb20",   0, 0, 2'b01, 0, 32'h20, 32'h0,        32'h00000001, 0);

    // Misalignment and illegal size.
    run_a("err_w02",   0, 0, 2'b11, 0, 32'h02, 32'h0, 32'h0, 1);
    run_a("err_h13",   0, 0, 2'b10, 0, 32'h13, 32'h0, 32'h0, 1);
    run_a("err_sz0",   0, 0, 2'b00, 0, 32'h00, 32'h0, 32'h0, 1);
    run_a("err_st_w1", 0, 1, 2'b11, 0, 32'h01, 32'h55, 32'h0, 1);
    run_a("ok_h22",    0, 0, 2'b10, 0, 32'h22, 32'h0, 32'h0, 0);

    // Contention with both requests held.
    m0_we = 0; m0_size = 2'b11; m0_addr = 32'h0; m0_uns = 0;
    m1_we = 0; m1_size = 2'b11; m1_addr = 32'h0; m1_uns = 0;
    m0_req = 1; m1_req = 1;
    k = 0; n = 0;
    while (k < 10 && n < 200) begin
      #1;
      if (a_m0_gnt || a_m1_gnt) begin
`ifdef DMEM_ARB_RR_EN
        // Last grant before this point went to M0, so M1 wins the first contention.
        exp_g = (k % 2 == 0) ? 32'd2 : 32'd1;
`else
        exp_g = (k % 5 == 4) ? 32'd2 : 32'd1;
`endif
        chk($sformatf("arb_gnt%0d", k), {30'h0, a_m1_gnt, a_m0_gnt}, exp_g);
        k++;
      end
      step();
      n++;
    end
    chk("arb_count", k, 32'd10);
    m0_req = 0; m1_req = 0;
    repeat (4) step();

    // M1 port path, and an M0 request raised and dropped while busy.
    run_a("m1_ub21", 1, 0, 2'b01, 1, 32'h21, 32'h0, 32'h00000080, 0);
    m1_req = 1; m1_we = 0; m1_size = 2'b11; m1_addr = 32'h0;
    #1;
    chk("m1_gnt_direct", {31'h0, a_m1_gnt}, 32'h1);
    step();
    m1_req = 0;
    m0_req = 1; m0_we = 0; m0_size = 2'b11; m0_addr = 32'h4;
    #1;
    chk("m0_ignored_busy", {31'h0, a_m0_gnt}, 32'h0);
    step();
    m0_req = 0;
    #1;
    chk("m1_rvalid", {31'h0, a_m1_rvalid}, 32'h1);
    chk("m1_rdata", a_m1_rdata, 32'hDEADBEEF);
    chk("m0_no_rvalid", {31'h0, a_m0_rvalid}, 32'h0);
    step();
    #1;
    chk("idle_after_drop", {31'h0, a_busy}, 32'h0);
    chk("no_late_m0_gnt", {31'h0, a_m0_gnt}, 32'h0);
    step();

    // Instance B, MEM_LAT=4: command held four cycles, response at t+5.
    m0_we = 0; m0_size = 2'b11; m0_uns = 0; m0_addr = 32'h40;
    b_m0_req = 1;
    #1;
    chk("b_gnt", {31'h0, b_m0_gnt}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      b_m0_req = 0;
      #1;
      chk($sformatf("b_read%0d", i), {30'h0, b_mem_read}, 32'd3);
      chk($sformatf("b_addr%0d", i), b_mem_addr, 32'h40);
      chk($sformatf("b_busy%0d", i), {31'h0, b_busy}, 32'h1);
      chk($sformatf("b_norv%0d", i), {31'h0, b_m0_rvalid}, 32'h0);
    end
    step();
    #1;
    chk("b_rvalid", {31'h0, b_m0_rvalid}, 32'h1);
    chk("b_rdata", b_m0_rdata, 32'hCAFEF00D);
    chk("b_resp_busy", {31'h0, b_busy}, 32'h1);
    chk("b_resp_read", {30'h0, b_mem_read}, 32'h0);
    step();
    #1;
    chk("b_idle", {31'h0, b_busy}, 32'h0);
    chk("b_rvalid_gone", {31'h0, b_m0_rvalid}, 32'h0);
    step();

    // Reset in the middle of a word store on instance B.
    m0_we = 1; m0_size = 2'b11; m0_addr = 32'h48; m0_wdata = 32'h0BADF00D;
    b_m0_req = 1;
    #1;
    chk("rs_gnt", {31'h0, b_m0_gnt}, 32'h1);
    step();
    b_m0_req = 0;
    step();
    #1;
    chk("rs_write_live", {30'h0, b_mem_write}, 32'd3);
    rst = 1;
    #1;
    chk("rs_write_drop", {30'h0, b_mem_write}, 32'h0);
    chk("rs_busy_drop", {31'h0, b_busy}, 32'h0);
    step();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      seen |= b_m0_rvalid | b_m1_rvalid;
      step();
    end
    chk("rs_no_rvalid", {31'h0, seen}, 32'h0);

    m1_we = 0; m1_size = 2'b11; m1_uns = 0; m1_addr = 32'h44;
    b_m1_req = 1;
    #1;
    chk("rs_m1_gnt", {31'h0, b_m1_gnt}, 32'h1);
    step();
    b_m1_req = 0;
    n = 1;
    #1;
    while (!b_m1_rvalid && n < 20) begin step(); #1; n++; end
    chk("rs_m1_lat", n, 32'd5);
    chk("rs_m1_rdata", b_m1_rdata, 32'hCAFEF00D);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
